router_ttl_rewrite: RTL and testbench

Downstream consumer of the IP checksum/TTL result queue in the router output-port-lookup pipeline. It holds the first two beats of every packet until the matching checksum/TTL verdict is available. It then either forwards the packet with the decremented TTL and the incrementally updated header checksum written into beat 0, or drops the whole packet. Per-reason drop counters are kept for the register interface.

---
 rtl/router_ttl_rewrite_if.sv | 16 +
 rtl/router_ttl_rewrite.sv | 136 +++++++++++++
 tb/tb_router_ttl_rewrite.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_ttl_rewrite_if.sv
// AXI4-Stream bundle used on both sides of the TTL rewrite stage.
// Master drives the beat and tvalid; slave returns tready.
interface router_ttl_rewrite_if #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [USER_W-1:0]   tuser;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, tkeep, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/router_ttl_rewrite.sv
// Holds the first two beats of each packet until the checksum/TTL verdict arrives,
// then forwards with TTL/checksum rewritten in beat 0 or drops the packet.
module router_ttl_rewrite #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
  input  logic                clk,
  input  logic                reset,
  router_ttl_rewrite_if.slave  s_axis,
  router_ttl_rewrite_if.master m_axis,
  input  logic                ip_checksum_vld,
  input  logic                ip_checksum_is_good,
  input  logic                ip_hdr_has_options,
  input  logic                ip_ttl_is_good,
  input  logic [7:0]          ip_new_ttl,
  input  logic [15:0]         ip_new_checksum,
  output logic                rd_checksum,
  output logic [31:0]         pkt_fwd_cnt,
  output logic [31:0]         pkt_drop_cksum_cnt,
  output logic [31:0]         pkt_drop_opt_cnt,
  output logic [31:0]         pkt_drop_ttl_cnt
);
  localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;

  typedef enum logic [2:0] {HDR0, HDR1, WAIT, OUT0, OUT1, PASS, DROP, SHORT} state_t;

  state_t                          state, state_nxt;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  h0_data, h1_data;
  logic [KEEP_W-1:0]               h0_keep, h1_keep;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] h0_user, h1_user;
  logic                            last1;
  logic                            drop_cksum, drop_opt, drop_ttl, fwd;

  // Fixed drop priority: bad checksum, then options, then expired TTL.
  assign drop_cksum = !ip_checksum_is_good;
  assign drop_opt   = ip_checksum_is_good && ip_hdr_has_options;
  assign drop_ttl   = ip_checksum_is_good && !ip_hdr_has_options && !ip_ttl_is_good;
  assign fwd        = ip_checksum_is_good && !ip_hdr_has_options && ip_ttl_is_good;

  always_ff @(posedge clk) begin
    if (reset) state <= HDR0;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    rd_checksum    = 1'b0;
    s_axis.tready  = 1'b0;
    m_axis.tvalid  = 1'b0;
    m_axis.tdata   = h0_data;
    m_axis.tkeep   = h0_keep;
    m_axis.tuser   = h0_user;
    m_axis.tlast   = 1'b0;
    case (state)
      HDR0: begin
        s_axis.tready = 1'b1;
        if (s_axis.tvalid) state_nxt = s_axis.tlast ? SHORT : HDR1;
      end
      HDR1: begin
        s_axis.tready = 1'b1;
        if (s_axis.tvalid) state_nxt = WAIT;
      end
      WAIT: begin
        if (ip_checksum_vld) begin
          rd_checksum = 1'b1;
          if (fwd)        state_nxt = OUT0;
          else if (last1) state_nxt = HDR0;
          else            state_nxt = DROP;
        end
      end
      OUT0: begin
        m_axis.tvalid = 1'b1;
        if (m_axis.tready) state_nxt = OUT1;
      end
      OUT1: begin
        m_axis.tvalid = 1'b1;
        m_axis.tdata  = h1_data;
        m_axis.tkeep  = h1_keep;
        m_axis.tuser  = h1_user;
        m_axis.tlast  = last1;
        if (m_axis.tready) state_nxt = last1 ? HDR0 : PASS;
      end
      PASS: begin
        m_axis.tvalid = s_axis.tvalid;
        m_axis.tdata  = s_axis.tdata;
        m_axis.tkeep  = s_axis.tkeep;
        m_axis.tuser  = s_axis.tuser;
        m_axis.tlast  = s_axis.tlast;
        s_axis.tready = m_axis.tready;
        if (s_axis.tvalid && m_axis.tready && s_axis.tlast) state_nxt = HDR0;
      end
      DROP: begin
        s_axis.tready = 1'b1;
        if (s_axis.tvalid && s_axis.tlast) state_nxt = HDR0;
      end
      SHORT: begin
        m_axis.tvalid = 1'b1;
        m_axis.tlast  = 1'b1;
        if (m_axis.tready) state_nxt = HDR0;
      end
      default: state_nxt = HDR0;
    endcase
  end

  // Header holding registers; beat 0 is patched in place on the verdict pop.
  always_ff @(posedge clk) begin
    if (state == HDR0 && s_axis.tvalid) begin
      h0_data <= s_axis.tdata;
      h0_keep <= s_axis.tkeep;
      h0_user <= s_axis.tuser;
    end else if (rd_checksum && fwd) begin
      h0_data[183:176] <= ip_new_ttl;
      h0_data[207:192] <= ip_new_checksum;
    end
    if (state == HDR1 && s_axis.tvalid) begin
      h1_data <= s_axis.tdata;
      h1_keep <= s_axis.tkeep;
      h1_user <= s_axis.tuser;
      last1   <= s_axis.tlast;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_fwd_cnt        <= '0;
      pkt_drop_cksum_cnt <= '0;
      pkt_drop_opt_cnt   <= '0;
      pkt_drop_ttl_cnt   <= '0;
    end else if (rd_checksum) begin
      if (fwd)        pkt_fwd_cnt        <= pkt_fwd_cnt + 32'd1;
      if (drop_cksum) pkt_drop_cksum_cnt <= pkt_drop_cksum_cnt + 32'd1;
      if (drop_opt)   pkt_drop_opt_cnt   <= pkt_drop_opt_cnt + 32'd1;
      if (drop_ttl)   pkt_drop_ttl_cnt   <= pkt_drop_ttl_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_router_ttl_rewrite.sv
// Bench for router_ttl_rewrite: vector table of packets/verdicts with an output
// scoreboard, plus directed late-verdict, single-beat and mid-packet reset sequences.
module tb_router_ttl_rewrite;
  localparam int DW = 256;
  localparam int UW = 128;
  localparam int KW = DW / 8;
  localparam int FWD = 0, DRP = 1, SHT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  router_ttl_rewrite_if #(.DATA_W(DW), .USER_W(UW)) s_if ();
  router_ttl_rewrite_if #(.DATA_W(DW), .USER_W(UW)) m_if ();

  logic        ip_checksum_vld, ip_checksum_is_good, ip_hdr_has_options, ip_ttl_is_good;
  logic [7:0]  ip_new_ttl;
  logic [15:0] ip_new_checksum;
  logic        rd_checksum;
  logic [31:0] c_fwd, c_ck, c_opt, c_ttl;

  router_ttl_rewrite #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW)) dut (
    .clk(clk), .reset(reset), .s_axis(s_if), .m_axis(m_if),
    .ip_checksum_vld(ip_checksum_vld), .ip_checksum_is_good(ip_checksum_is_good),
    .ip_hdr_has_options(ip_hdr_has_options), .ip_ttl_is_good(ip_ttl_is_good),
    .ip_new_ttl(ip_new_ttl), .ip_new_checksum(ip_new_checksum), .rd_checksum(rd_checksum),
    .pkt_fwd_cnt(c_fwd), .pkt_drop_cksum_cnt(c_ck), .pkt_drop_opt_cnt(c_opt),
    .pkt_drop_ttl_cnt(c_ttl)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  typedef struct {
    logic        good, opts, ttlg;
    logic [7:0]  nttl;
    logic [15:0] nck;
  } verdict_t;

  typedef struct {
    int          n;
    logic [7:0]  ttl;
    logic        good, opts, ttlg;
    logic [7:0]  nttl;
    logic [15:0] nck;
    int          fate;
    int          e_fwd, e_ck, e_opt, e_ttl;
  } vec_t;

  beat_t    exq[$];
  verdict_t vq[$];
  verdict_t late_v, vdummy;
  int tests = 0, fails = 0, cyc = 0;
  int rd_pulses = 0, wait_viol = 0, late_cnt = 0;
  int hs1_cyc = 0, rd_cyc = 0, mv_cyc = 0;
  bit wait_watch = 0, mv_seen = 0, bp = 0, s_hs = 0, stall_prev = 0;
  beat_t stall_beat;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, required completion before 500us");
    $fatal(1);
  end

  function automatic void check_eq(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  function automatic void check_beat(string name, beat_t a, beat_t e);
    tests++;
    if (a.d !== e.d || a.k !== e.k || a.u !== e.u || a.l !== e.l) begin
      fails++;
      $display("FAIL %s: got d=%h k=%h u=%h l=%b, required d=%h k=%h u=%h l=%b",
               name, a.d, a.k, a.u, a.l, e.d, e.k, e.u, e.l);
    end
  endfunction

  function automatic logic [DW-1:0] rand_d();
    logic [DW-1:0] r;
    for (int j = 0; j < DW / 32; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [UW-1:0] rand_u();
    logic [UW-1:0] r;
    for (int j = 0; j < UW / 32; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic void drive_verdict();
    if (vq.size() > 0) begin
      ip_checksum_vld     = 1'b1;
      ip_checksum_is_good = vq[0].good;
      ip_hdr_has_options  = vq[0].opts;
      ip_ttl_is_good      = vq[0].ttlg;
      ip_new_ttl          = vq[0].nttl;
      ip_new_checksum     = vq[0].nck;
    end else begin
      ip_checksum_vld     = 1'b0;
      ip_checksum_is_good = 1'b0;
      ip_hdr_has_options  = 1'b0;
      ip_ttl_is_good      = 1'b0;
      ip_new_ttl          = 8'h00;
      ip_new_checksum     = 16'h0000;
    end
  endfunction

  task automatic push_v(input logic good, input logic opts, input logic ttlg,
                        input logic [7:0] nttl, input logic [15:0] nck);
    verdict_t v;
    v.good = good; v.opts = opts; v.ttlg = ttlg; v.nttl = nttl; v.nck = nck;
    vq.push_back(v);
    drive_verdict();
  endtask

  // One clock: observe at negedge, advance past posedge, update TB-side inputs.
  task automatic step();
    beat_t cur;
    bit    pop_req;
    pop_req = 0;
    @(negedge clk);
    cur.d = m_if.tdata; cur.k = m_if.tkeep; cur.u = m_if.tuser; cur.l = m_if.tlast;
    if (stall_prev && !reset) begin
      tests++;
      if (!m_if.tvalid || cur.d !== stall_beat.d || cur.l !== stall_beat.l ||
          cur.k !== stall_beat.k || cur.u !== stall_beat.u) begin
        fails++;
        $display("FAIL axi_hold: got tvalid=%b after stall, required stable held beat", m_if.tvalid);
      end
    end
    stall_prev = m_if.tvalid && !m_if.tready && !reset;
    stall_beat = cur;
    if (m_if.tvalid && !mv_seen) begin mv_seen = 1; mv_cyc = cyc; end
    if (m_if.tvalid && m_if.tready) begin
      if (exq.size() == 0) begin
        tests++; fails++;
        $display("FAIL out_beat: got unexpected beat d=%h, required no output", cur.d);
      end else begin
        check_beat("out_beat", cur, exq.pop_front());
      end
    end
    if (rd_checksum) begin
      rd_pulses++;
      rd_cyc = cyc;
      wait_watch = 0;
      pop_req = 1;
      check_eq("rd_needs_vld", {31'd0, ip_checksum_vld}, 32'd1);
    end
    if (wait_watch && s_if.tready) wait_viol++;
    s_hs = s_if.tvalid && s_if.tready;
    @(posedge clk);
    #1;
    cyc++;
    if (pop_req && vq.size() > 0) vdummy = vq.pop_front();
    if (late_cnt > 0) begin
      late_cnt--;
      if (late_cnt == 0) vq.push_back(late_v);
    end
    drive_verdict();
    m_if.tready = bp ? ~m_if.tready : 1'b1;
  endtask

  task automatic send_pkt(input int n, input logic [7:0] ttl_in, input int fate,
                          input logic [7:0] nttl, input logic [15:0] nck,
                          input int late, input int rst_beat);
    beat_t b[16];
    beat_t e;
    int    guard;
    for (int i = 0; i < n; i++) begin
      b[i].d = rand_d(); b[i].k = $urandom; b[i].u = rand_u(); b[i].l = (i == n - 1);
    end
    b[0].d[183:176] = ttl_in;
    if (fate == SHT) exq.push_back(b[0]);
    if (fate == FWD) begin
      for (int i = 0; i < n; i++) begin
        e = b[i];
        if (i == 0) begin e.d[183:176] = nttl; e.d[207:192] = nck; end
        exq.push_back(e);
      end
    end
    for (int i = 0; i < n; i++) begin
      s_if.tdata = b[i].d; s_if.tkeep = b[i].k; s_if.tuser = b[i].u; s_if.tlast = b[i].l;
      s_if.tvalid = 1'b1;
      if (i == rst_beat) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        s_if.tvalid = 1'b0;
        exq.delete();
        stall_prev = 0;
        return;
      end
      guard = 0;
      do begin step(); guard++; end while (!s_hs && guard < 200);
      if (!s_hs) begin
        tests++; fails++;
        $display("FAIL send_timeout: beat %0d not accepted, required accept within 200 cycles", i);
        s_if.tvalid = 1'b0;
        return;
      end
      if (i == 1) begin
        hs1_cyc = cyc - 1;
        wait_watch = 1;
        if (late > 0) late_cnt = late;
      end
    end
    s_if.tvalid = 1'b0;
    for (int g = 0; g < 300; g++) begin
      if (exq.size() == 0 && !m_if.tvalid && late_cnt == 0) break;
      step();
    end
    if (exq.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d beats outstanding, required 0", exq.size());
      exq.delete();
    end
    for (int g = 0; g < 3; g++) step();
  endtask

  vec_t vecs[8];
  int   rd0;

  initial begin
    vecs[0] = '{4, 8'h40, 1'b1, 1'b0, 1'b1, 8'h3F, 16'hB1E6, FWD, 1, 0, 0, 0};
    vecs[1] = '{3, 8'h20, 1'b1, 1'b0, 1'b0, 8'h1F, 16'h1234, DRP, 1, 0, 0, 1};
    vecs[2] = '{3, 8'h40, 1'b0, 1'b1, 1'b1, 8'h3F, 16'h0000, DRP, 1, 1, 0, 1};
    vecs[3] = '{5, 8'h80, 1'b1, 1'b1, 1'b1, 8'h7F, 16'h5555, DRP, 1, 1, 1, 1};
    vecs[4] = '{2, 8'h02, 1'b1, 1'b0, 1'b1, 8'h01, 16'hABCD, FWD, 2, 1, 1, 1};
    vecs[5] = '{1, 8'h11, 1'b1, 1'b1, 1'b1, 8'h00, 16'h0000, SHT, 2, 1, 1, 1};
    vecs[6] = '{2, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 16'hFFFF, DRP, 2, 2, 1, 1};
    vecs[7] = '{6, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hFE, 16'h0F0F, FWD, 3, 2, 1, 1};

    reset = 1'b1;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tuser = '0; s_if.tlast = 1'b0;
    m_if.tready = 1'b1;
    drive_verdict();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_s_tready", {31'd0, s_if.tready}, 32'd1);
    check_eq("rst_m_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    check_eq("rst_rd", {31'd0, rd_checksum}, 32'd0);
    check_eq("rst_cnt_sum", c_fwd | c_ck | c_opt | c_ttl, 32'd0);
    @(posedge clk);
    #1;

    for (int v = 0; v < 8; v++) begin
      rd0 = rd_pulses;
      mv_seen = 0;
      if (vecs[v].n >= 2)
        push_v(vecs[v].good, vecs[v].opts, vecs[v].ttlg, vecs[v].nttl, vecs[v].nck);
      send_pkt(vecs[v].n, vecs[v].ttl, vecs[v].fate, vecs[v].nttl, vecs[v].nck, 0, -1);
      check_eq($sformatf("v%0d_fwd_cnt", v), c_fwd, vecs[v].e_fwd);
      check_eq($sformatf("v%0d_cksum_cnt", v), c_ck, vecs[v].e_ck);
      check_eq($sformatf("v%0d_opt_cnt", v), c_opt, vecs[v].e_opt);
      check_eq($sformatf("v%0d_ttl_cnt", v), c_ttl, vecs[v].e_ttl);
      check_eq($sformatf("v%0d_rd_pulses", v), rd_pulses - rd0, (vecs[v].n >= 2) ? 1 : 0);
      if (v == 0) begin
        check_eq("lat_rd", rd_cyc, hs1_cyc + 1);
        check_eq("lat_out0", mv_cyc, hs1_cyc + 2);
      end
    end

    // Late verdict with toggling downstream ready.
    bp = 1; wait_viol = 0; rd0 = rd_pulses;
    late_v.good = 1'b1; late_v.opts = 1'b0; late_v.ttlg = 1'b1;
    late_v.nttl = 8'h07; late_v.nck = 16'h2468;
    send_pkt(4, 8'h08, FWD, 8'h07, 16'h2468, 10, -1);
    bp = 0; m_if.tready = 1'b1;
    check_eq("late_wait_tready", wait_viol, 0);
    check_eq("late_rd_pulses", rd_pulses - rd0, 1);
    check_eq("late_fwd_cnt", c_fwd, 4);

    // Single-beat packet must leave the pending verdict for the next packet.
    rd0 = rd_pulses;
    push_v(1'b1, 1'b0, 1'b1, 8'h55, 16'h1111);
    send_pkt(1, 8'h56, SHT, 8'h00, 16'h0000, 0, -1);
    check_eq("short_no_pop", rd_pulses - rd0, 0);
    check_eq("short_vq_kept", vq.size(), 1);
    send_pkt(2, 8'h56, FWD, 8'h55, 16'h1111, 0, -1);
    check_eq("short_then_two_rd", rd_pulses - rd0, 1);
    check_eq("short_then_two_fwd", c_fwd, 5);

    // Reset while beat 3 of a 6-beat packet streams through.
    push_v(1'b1, 1'b0, 1'b1, 8'h20, 16'h3333);
    send_pkt(6, 8'h21, FWD, 8'h20, 16'h3333, 0, 3);
    @(negedge clk);
    check_eq("mid_rst_m_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    check_eq("mid_rst_cnt_sum", c_fwd | c_ck | c_opt | c_ttl, 32'd0);
    @(posedge clk);
    #1;
    vq.delete();
    drive_verdict();
    push_v(1'b1, 1'b0, 1'b1, 8'h09, 16'h4444);
    send_pkt(3, 8'h0A, FWD, 8'h09, 16'h4444, 0, -1);
    check_eq("post_rst_fwd", c_fwd, 1);
    check_eq("post_rst_drop_sum", c_ck | c_opt | c_ttl, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
